// File: rtl/turbo_enc_ctrl.sv
// Frame sequencer for the LTE turbo encoder: natural/QPP read addressing, 3-cycle tail window.
// Optional macro TURBO_CTRL_ABORT_EN adds an abort input that cancels a frame in flight.
module turbo_enc_ctrl #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          req,
  input  logic          K,
`ifdef TURBO_CTRL_ABORT_EN
  input  logic          abort,
`endif
  output logic          ack,
  output logic          enc_start,
  output logic          enc_clr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] il_addr,
  output logic          ck_valid,
  output logic          tail,
  output logic          busy,
  output logic          done,
  output logic          frame_k
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_TAIL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [AW-1:0] KSZ_S   = AW'(13'd1056);
  localparam logic [AW-1:0] KSZ_L   = AW'(13'd6144);
  localparam logic [AW-1:0] G0_S    = AW'(13'd83);
  localparam logic [AW-1:0] G0_L    = AW'(13'd743);
  localparam logic [AW-1:0] TWOF2_S = AW'(13'd132);
  localparam logic [AW-1:0] TWOF2_L = AW'(13'd960);

  // Both operands are below ksz, so one conditional subtract reduces the sum.
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW-1:0] ksz);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, ksz}) begin
      mod_add = AW'(sum - {1'b0, ksz});
    end else begin
      mod_add = sum[AW-1:0];
    end
  endfunction

  logic [2:0]    state_r, state_s;
  logic [AW-1:0] rd_addr_r, rd_addr_s, il_addr_r, il_addr_s, g_r, g_s;
  logic [1:0]    tail_cnt_r, tail_cnt_s;
  logic          ack_r, ack_s, enc_clr_r, enc_clr_s, rd_en_r, rd_en_s;
  logic          ck_valid_r, ck_valid_s, tail_r, tail_s, busy_r, busy_s;
  logic          done_r, done_s, frame_k_r, frame_k_s, abort_s;
  logic [AW-1:0] ksz_s, two_f2_s;

  assign ksz_s    = frame_k_r ? KSZ_L : KSZ_S;
  assign two_f2_s = frame_k_r ? TWOF2_L : TWOF2_S;

`ifdef TURBO_CTRL_ABORT_EN
  assign abort_s = abort && ((state_r == ST_DATA) || (state_r == ST_DRAIN) || (state_r == ST_TAIL));
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s    = state_r;
    rd_addr_s  = {AW{1'b0}};
    il_addr_s  = {AW{1'b0}};
    g_s        = {AW{1'b0}};
    tail_cnt_s = 2'd0;
    ack_s      = 1'b0;
    enc_clr_s  = 1'b0;
    rd_en_s    = 1'b0;
    ck_valid_s = 1'b0;
    tail_s     = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    frame_k_s  = frame_k_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          state_s   = ST_DATA;
          ack_s     = 1'b1;
          rd_en_s   = 1'b1;
          busy_s    = 1'b1;
          frame_k_s = K;
          g_s       = K ? G0_L : G0_S;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        busy_s     = 1'b1;
        ck_valid_s = 1'b1;
        if (rd_addr_r == ksz_s - AW'(1'b1)) begin
          state_s = ST_DRAIN;
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = rd_addr_r + AW'(1'b1);
          il_addr_s = mod_add(il_addr_r, g_r, ksz_s);
          g_s       = mod_add(g_r, two_f2_s, ksz_s);
        end
      end
      ST_DRAIN: begin
        state_s = ST_TAIL;
        tail_s  = 1'b1;
        busy_s  = 1'b1;
      end
      ST_TAIL: begin
        busy_s = 1'b1;
        if (tail_cnt_r == 2'd2) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          tail_s     = 1'b1;
          tail_cnt_s = tail_cnt_r + 2'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (abort_s) begin
      state_s    = ST_IDLE;
      rd_addr_s  = {AW{1'b0}};
      il_addr_s  = {AW{1'b0}};
      g_s        = {AW{1'b0}};
      tail_cnt_s = 2'd0;
      ack_s      = 1'b0;
      enc_clr_s  = 1'b1;
      rd_en_s    = 1'b0;
      ck_valid_s = 1'b0;
      tail_s     = 1'b0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
    end else begin
      enc_clr_s = 1'b0;
    end
  end

  // State and output registers; aclr clears everything and raises enc_clr next cycle.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_r    <= ST_IDLE;
      rd_addr_r  <= {AW{1'b0}};
      il_addr_r  <= {AW{1'b0}};
      g_r        <= {AW{1'b0}};
      tail_cnt_r <= 2'd0;
      ack_r      <= 1'b0;
      enc_clr_r  <= 1'b1;
      rd_en_r    <= 1'b0;
      ck_valid_r <= 1'b0;
      tail_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      frame_k_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      rd_addr_r  <= rd_addr_s;
      il_addr_r  <= il_addr_s;
      g_r        <= g_s;
      tail_cnt_r <= tail_cnt_s;
      ack_r      <= ack_s;
      enc_clr_r  <= enc_clr_s;
      rd_en_r    <= rd_en_s;
      ck_valid_r <= ck_valid_s;
      tail_r     <= tail_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      frame_k_r  <= frame_k_s;
    end
  end

  assign ack       = ack_r;
  assign enc_start = ack_r;
  assign enc_clr   = enc_clr_r;
  assign rd_en     = rd_en_r;
  assign rd_addr   = rd_addr_r;
  assign il_addr   = il_addr_r;
  assign ck_valid  = ck_valid_r;
  assign tail      = tail_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign frame_k   = frame_k_r;

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Directed self-checking bench for turbo_enc_ctrl; expected QPP addresses use the closed form f1*i+f2*i^2 mod K.
module tb_turbo_enc_ctrl;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          aclr, req, K;
`ifdef TURBO_CTRL_ABORT_EN
  logic          abort;
`endif
  logic          ack, enc_start, enc_clr, rd_en, ck_valid, tail, busy, done, frame_k;
  logic [AW-1:0] rd_addr, il_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int seen [0:6143];

  turbo_enc_ctrl #(.AW(AW)) dut (
    .clk(clk), .aclr(aclr), .req(req), .K(K),
`ifdef TURBO_CTRL_ABORT_EN
    .abort(abort),
`endif
    .ack(ack), .enc_start(enc_start), .enc_clr(enc_clr), .rd_en(rd_en),
    .rd_addr(rd_addr), .il_addr(il_addr), .ck_valid(ck_valid), .tail(tail),
    .busy(busy), .done(done), .frame_k(frame_k)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint qpp(input int kbit, input longint i);
    longint ksz, f1, f2;
    ksz = kbit ? 64'd6144 : 64'd1056;
    f1  = kbit ? 64'd263 : 64'd17;
    f2  = kbit ? 64'd480 : 64'd66;
    return (f1 * i + f2 * i * i) % ksz;
  endfunction

  // Called in cycle S; checks offsets 0..last, leaving the bench in cycle S+last.
  task automatic run_frame(input int kbit, input int last, input bit drop_req, input int flip_at);
    int ksz;
    int nrd;
    ksz = kbit ? 6144 : 1056;
    nrd = 0;
    for (int i = 0; i < 6144; i++) seen[i] = 0;
    for (int n = 0; n <= last; n++) begin
      check("ack",       ack,       (n == 0));
      check("enc_start", enc_start, (n == 0));
      check("rd_en",     rd_en,     (n < ksz));
      check("rd_addr",   rd_addr,   (n < ksz) ? n : 0);
      check("il_addr",   il_addr,   (n < ksz) ? qpp(kbit, n) : 0);
      check("ck_valid",  ck_valid,  (n >= 1 && n <= ksz));
      check("tail",      tail,      (n >= ksz + 1 && n <= ksz + 3));
      check("done",      done,      (n == ksz + 4));
      check("busy",      busy,      1);
      check("frame_k",   frame_k,   kbit);
      check("enc_clr",   enc_clr,   0);
      if (rd_en) begin
        nrd++;
        seen[il_addr] = seen[il_addr] + 1;
      end
      if (n == 0 && drop_req) req = 1'b0;
      if (n == flip_at) K = ~K;
      if (n < last) tick();
    end
    if (last == ksz + 4) begin
      int dup;
      dup = 0;
      for (int i = 0; i < ksz; i++) if (seen[i] != 1) dup++;
      check("rd_en_count", nrd, ksz);
      check("pi_perm_errs", dup, 0);
    end
  endtask

  initial begin
    int ndone;
    aclr = 1'b1; req = 1'b0; K = 1'b0;
`ifdef TURBO_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    check("rst_enc_clr", enc_clr, 1);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_il", il_addr, 0);
    check("rst_frame_k", frame_k, 0);
    aclr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_enc_clr", enc_clr, 0);
      check("idle_busy", busy, 0);
      check("idle_out", {ack, enc_start, rd_en, ck_valid, tail, done}, 0);
      check("idle_addr", rd_addr + il_addr, 0);
    end

    // K=1056 frame
    req = 1'b1; K = 1'b0;
    tick();
    run_frame(0, 1060, 1'b1, -1);
    tick();
    check("post_busy", busy, 0);
    check("post_ack", ack, 0);
    check("post_done", done, 0);

    // K=6144 frame, full permutation
    req = 1'b1; K = 1'b1;
    tick();
    run_frame(1, 6148, 1'b1, -1);
    tick();
    check("post6144_busy", busy, 0);

    // Back-to-back: req held across DONE, K flipped mid-frame (ignored until next accept)
    req = 1'b1; K = 1'b0;
    tick();
    run_frame(0, 1060, 1'b0, 10);
    tick();
    check("b2b_ack", ack, 1);
    check("b2b_frame_k", frame_k, 1);
    run_frame(1, 6148, 1'b1, -1);
    tick();

    // aclr in the middle of a K=0 frame
    req = 1'b1; K = 1'b0;
    tick();
    run_frame(0, 500, 1'b1, -1);
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    check("aclr_busy", busy, 0);
    check("aclr_enc_clr", enc_clr, 1);
    check("aclr_rd_en", rd_en, 0);
    check("aclr_ck_valid", ck_valid, 0);
    check("aclr_il", il_addr, 0);
    ndone = 0;
    for (int c = 0; c < 1070; c++) begin
      tick();
      if (done || busy) ndone++;
    end
    check("aclr_no_done", ndone, 0);
    req = 1'b1; K = 1'b0;
    tick();
    run_frame(0, 1060, 1'b1, -1);
    tick();

`ifdef TURBO_CTRL_ABORT_EN
    // Abort inside the tail window
    req = 1'b1; K = 1'b0;
    tick();
    run_frame(0, 1058, 1'b1, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_enc_clr", enc_clr, 1);
    check("abort_tail", tail, 0);
    check("abort_busy", busy, 0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check("abort_idle_enc_clr", enc_clr, 0);
    check("abort_idle_busy", busy, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
